// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_seq execute-stage ALU.
//   - Opcode values ALU_ADD .. ALU_DIVU (4-bit aluCtr encoding).
//   - FSM state enum (IDLE, RUN, DONE).
//   - is_iterative(): which opcodes use the WIDTH-cycle shift engine.
// Configuration macro: ALU_DIV_EN (when undefined, DIVU is not iterative and
// is handled as an undefined single-cycle code).
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_OR    = 4'd2;
  localparam logic [3:0] ALU_AND   = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_SLL   = 4'd8;
  localparam logic [3:0] ALU_SRL   = 4'd9;
  localparam logic [3:0] ALU_SRA   = 4'd10;
  localparam logic [3:0] ALU_MULTU = 4'd11;
  localparam logic [3:0] ALU_DIVU  = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True for opcodes that go through RUN instead of completing in one cycle.
  function automatic logic is_iterative(input logic [3:0] op);
`ifdef ALU_DIV_EN
    return (op == ALU_MULTU) || (op == ALU_DIVU);
`else
    return (op == ALU_MULTU);
`endif
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: shared WIDTH-step shift engine for MULTU (shift-add) and, when
// ALU_DIV_EN is defined, DIVU (restoring division).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_load          capture operands, clear partial result and counter
//   i_step          perform one iteration
//   i_div           (ALU_DIV_EN only) 1 = divide, 0 = multiply; sampled on load
//   i_a, i_b        operands (multiplier/dividend, multiplicand/divisor)
//   o_last          the current step is the final (WIDTH-th) iteration
//   o_hi_nxt/o_lo_nxt  register values after the current step; on the last
//                   step these are the finished {hi,lo} pair
// Configuration macro: ALU_DIV_EN.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
`ifdef ALU_DIV_EN
  input  logic             i_div,
`endif
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_hi_nxt,
  output logic [WIDTH-1:0] o_lo_nxt
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [SHW-1:0]   r_cnt;
`ifdef ALU_DIV_EN
  logic             r_div;
`endif

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;

  // Multiply: {carry,hi,lo} accumulates the product; lo starts as the
  // multiplier and its consumed bits shift out the bottom.
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_mul_hi  = w_mul_sum[WIDTH:1];
    w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
  end

`ifdef ALU_DIV_EN
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;

  // Divide: hi is the partial remainder, lo holds the dividend and collects
  // quotient bits from the bottom. The remainder stays below the divisor, so
  // the top bit of the WIDTH+1 bit difference is a clean borrow. A zero
  // divisor never borrows, giving an all-ones quotient and remainder = busA.
  always_comb begin
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, r_b};
    if (!w_div_diff[WIDTH]) begin
      w_div_hi = w_div_diff[WIDTH-1:0];
      w_div_lo = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_div_hi = w_div_shift[WIDTH-1:0];
      w_div_lo = {r_lo[WIDTH-2:0], 1'b0};
    end
  end

  assign o_hi_nxt = r_div ? w_div_hi : w_mul_hi;
  assign o_lo_nxt = r_div ? w_div_lo : w_mul_lo;
`else
  assign o_hi_nxt = w_mul_hi;
  assign o_lo_nxt = w_mul_lo;
`endif

  assign o_last = (r_cnt == SHW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_cnt <= '0;
`ifdef ALU_DIV_EN
      r_div <= 1'b0;
`endif
    end else if (i_load) begin
      r_hi  <= '0;
      r_lo  <= i_a;
      r_b   <= i_b;
      r_cnt <= '0;
`ifdef ALU_DIV_EN
      r_div <= i_div;
`endif
    end else if (i_step) begin
      r_hi  <= o_hi_nxt;
      r_lo  <= o_lo_nxt;
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered, parametrised ALU with a start/done handshake.
// Handshake: start/aluCtr/busA/busB are sampled only while idle (busy = 0);
// an accepted op always ends with exactly one cycle of done = 1, at which
// point alu_out/zero_flag/overflow (and hi/lo for MULTU/DIVU) are valid and
// they hold until the next completed op. start is ignored while busy.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, aluCtr         request and 4-bit opcode
//   busA, busB            operands (WIDTH bits)
//   busy, done            state != IDLE, one-cycle completion pulse
//   alu_out, zero_flag    registered result and (alu_out == 0)
//   overflow              signed overflow of ADD/SUB, else 0
//   hi, lo                MULTU product / DIVU remainder,quotient
// Configuration macro: ALU_DIV_EN (builds the divider for DIVU).
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       aluCtr,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero_flag,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_step;
  logic             w_fin_single;
  logic             w_fin_iter;

  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_ovf;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_last;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_fin_single = 1'b0;
    w_fin_iter   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (is_iterative(aluCtr)) begin
            w_state_nxt = RUN;
            w_load      = 1'b1;
          end else begin
            w_state_nxt  = DONE;
            w_fin_single = 1'b1;
          end
        end
      end
      RUN: begin
        // The final iteration and the result load share one edge, so RUN
        // lasts exactly WIDTH cycles.
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
          w_fin_iter  = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------- single-cycle datapath
  always_comb begin
    w_sum  = busA + busB;
    w_diff = busA - busB;
    w_sh   = busB[SHW-1:0];
    w_res  = '0;
    w_ovf  = 1'b0;
    case (aluCtr)
      ALU_ADD: begin
        w_res = w_sum;
        w_ovf = (busA[WIDTH-1] == busB[WIDTH-1]) && (w_sum[WIDTH-1] != busA[WIDTH-1]);
      end
      ALU_SUB: begin
        w_res = w_diff;
        w_ovf = (busA[WIDTH-1] != busB[WIDTH-1]) && (w_diff[WIDTH-1] != busA[WIDTH-1]);
      end
      ALU_OR:   w_res = busA | busB;
      ALU_AND:  w_res = busA & busB;
      ALU_XOR:  w_res = busA ^ busB;
      ALU_NOR:  w_res = ~(busA | busB);
      ALU_SLT:  w_res = WIDTH'($signed(busA) < $signed(busB));
      ALU_SLTU: w_res = WIDTH'(busA < busB);
      ALU_SLL:  w_res = busA << w_sh;
      ALU_SRL:  w_res = busA >> w_sh;
      ALU_SRA:  w_res = $unsigned($signed(busA) >>> w_sh);
      // MULTU/DIVU never complete here when iterative; undefined codes
      // (and DIVU without the divider) produce 0.
      default:  w_res = '0;
    endcase
  end

  // -------------------------------------------------------- shift engine
  alu_muldiv #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
`ifdef ALU_DIV_EN
    .i_div    (aluCtr == ALU_DIVU),
`endif
    .i_a      (busA),
    .i_b      (busB),
    .o_last   (w_last),
    .o_hi_nxt (w_hi_nxt),
    .o_lo_nxt (w_lo_nxt)
  );

  // ---------------------------------------------------- result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_zero <= 1'b1;
      r_ovf  <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else if (w_fin_single) begin
      r_out  <= w_res;
      r_zero <= (w_res == '0);
      r_ovf  <= w_ovf;
    end else if (w_fin_iter) begin
      r_out  <= w_lo_nxt;
      r_zero <= (w_lo_nxt == '0);
      r_ovf  <= 1'b0;
      r_hi   <= w_hi_nxt;
      r_lo   <= w_lo_nxt;
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign alu_out   = r_out;
  assign zero_flag = r_zero;
  assign overflow  = r_ovf;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a
// behavioural model built from plain integer arithmetic.
// Honours ALU_DIV_EN the same way as the design.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  // ------------------------------------------------ clock / reset block
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   aluCtr;
  logic [W-1:0] busA;
  logic [W-1:0] busB;
  logic         busy;
  logic         done;
  logic [W-1:0] alu_out;
  logic         zero_flag;
  logic         overflow;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .aluCtr    (aluCtr),
    .busA      (busA),
    .busB      (busB),
    .busy      (busy),
    .done      (done),
    .alu_out   (alu_out),
    .zero_flag (zero_flag),
    .overflow  (overflow),
    .hi        (hi),
    .lo        (lo)
  );

  // ------------------------------------------------------- scoreboard
  int           n_cmp  = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_iter(input logic [3:0] op);
`ifdef ALU_DIV_EN
    return (op == 4'd11) || (op == 4'd12);
`else
    return (op == 4'd11);
`endif
  endfunction

  // Reference behaviour from the arithmetic definition of each op.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] out, output logic ovf);
    int          ia;
    int          ib;
    int          sh;
    longint      wide;
    logic [63:0] prod;
    ia  = a;
    ib  = b;
    sh  = int'(b % W);
    out = '0;
    ovf = 1'b0;
    case (op)
      4'd0: begin wide = longint'(ia) + longint'(ib); out = wide[W-1:0];
                  ovf = (wide != longint'($signed(out))); end
      4'd1: begin wide = longint'(ia) - longint'(ib); out = wide[W-1:0];
                  ovf = (wide != longint'($signed(out))); end
      4'd2:  out = a | b;
      4'd3:  out = a & b;
      4'd4:  out = a ^ b;
      4'd5:  out = ~(a | b);
      4'd6:  out = (ia < ib) ? 1 : 0;
      4'd7:  out = (a < b) ? 1 : 0;
      4'd8:  out = a << sh;
      4'd9:  out = a >> sh;
      4'd10: out = ia >>> sh;
      4'd11: begin prod = 64'(a) * 64'(b); m_hi = prod[63:32]; m_lo = prod[31:0]; out = m_lo; end
`ifdef ALU_DIV_EN
      4'd12: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
        out = m_lo;
      end
`endif
      default: out = '0;
    endcase
  endtask

  // ------------------------------------------------------ driver tasks
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag, input bit mid_start);
    logic [W-1:0] e_out;
    logic         e_ovf;
    int           e_lat;
    int           lat;
    model(op, a, b, e_out, e_ovf);
    exp_q.push_back(e_out);
    e_lat = model_iter(op) ? W + 1 : 1;
    @(posedge clk); #1;
    start = 1'b1; aluCtr = op; busA = a; busB = b;
    @(posedge clk); #1;
    start = 1'b0; aluCtr = 4'($urandom); busA = $urandom; busB = $urandom;
    lat = 1;
    if (e_lat > 1) chk({tag, "_busy_run"}, 64'(busy), 64'(1));
    while (!done && lat < 200) begin
      start = mid_start && (lat == 5);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(e_lat));
    chk({tag, "_alu_out"}, 64'(alu_out), 64'(exp_q.pop_front()));
    chk({tag, "_zero"}, 64'(zero_flag), 64'(e_out == 0));
    chk({tag, "_ovf"}, 64'(overflow), 64'(e_ovf));
    chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'(0));
    chk({tag, "_busy_after"}, 64'(busy), 64'(0));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_alu_out"}, 64'(alu_out), 64'(0));
    chk({tag, "_zero"}, 64'(zero_flag), 64'(1));
    chk({tag, "_ovf"}, 64'(overflow), 64'(0));
    chk({tag, "_hi"}, 64'(hi), 64'(0));
    chk({tag, "_lo"}, 64'(lo), 64'(0));
  endtask

  // --------------------------------------------------------- stimulus
  initial begin
    bit           seen_done;
    logic [3:0]   r_op;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;

    rst = 1'b1; start = 1'b0; aluCtr = '0; busA = '0; busB = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    chk_reset_vals("idle");

    run_op(ALU_ADD, 32'h7FFF_FFFF, 32'h1, "add_ovf", 1'b0);
    run_op(ALU_SUB, 32'd5, 32'd5, "sub_zero", 1'b0);
    run_op(ALU_SRA, 32'h8000_0000, 32'd4, "sra", 1'b0);
    run_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, "slt", 1'b0);
    run_op(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, "sltu", 1'b0);
    run_op(ALU_SUB, 32'h8000_0000, 32'd1, "sub_ovf", 1'b0);
    run_op(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b1);
    run_op(ALU_DIVU, 32'd100, 32'd7, "divu", 1'b0);
    run_op(ALU_DIVU, 32'd9, 32'd0, "divu_by0", 1'b0);
    run_op(4'd14, 32'h1234_5678, 32'h9, "undef", 1'b0);

    // Reset in the middle of a MULTU: no done, reset values everywhere.
    @(posedge clk); #1;
    start = 1'b1; aluCtr = ALU_MULTU; busA = $urandom; busB = $urandom | 32'h1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    chk_reset_vals("rst_mid_run");
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen_done = seen_done | done;
    end
    chk("rst_mid_run_no_done", 64'(seen_done), 64'(0));

    // start and rst together: reset wins.
    rst = 1'b1; start = 1'b1; aluCtr = ALU_ADD; busA = 32'd1; busB = 32'd1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 64'(busy), 64'(0));
    chk("rst_start_done", 64'(done), 64'(0));

    run_op(ALU_ADD, 32'd2, 32'd3, "add_after_rst", 1'b0);

    // Randomized ops against the model.
    for (int i = 0; i < 40; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 5))
        0: r_a = '0;
        1: r_b = '0;
        2: r_a = 32'h7FFF_FFFF;
        3: r_b = 32'h8000_0000;
        default: ;
      endcase
      run_op(r_op, r_a, r_b, $sformatf("rnd%0d_op%0d", i, r_op), ($urandom_range(0, 1) == 1));
    end

    // ------------------------------------------------------ final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised ALU with a start/done handshake for the datapath execute stage. Adds AND, XOR, NOR, set-less-than, shifts and signed-overflow detection, plus iterative unsigned multiply and divide that write a HI/LO pair over WIDTH cycles. The controller issues `start` with an operation code and waits for `done`. Results, flags and HI/LO are held until the next completed operation.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; ≥ 8, power of two.
- `SHW`, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- `clk` input 1, single clock; all logic on rising edge.
- `rst` input 1, reset: synchronous, active-high.
- `start` input 1, request; sampled only in IDLE.
- `aluCtr` input 4, operation code, sampled with `start`.
- `busA` input WIDTH, operand one, sampled with `start`.
- `busB` input WIDTH, operand two, sampled with `start`.
- `busy` output 1, high whenever state ≠ IDLE.
- `done` output 1, one-cycle completion pulse.
- `alu_out` output WIDTH, registered result.
- `zero_flag` output 1, `alu_out == 0`, updated with `alu_out`.
- `overflow` output 1, signed overflow of ADD/SUB; 0 for all other ops.
- `hi`, `lo` output WIDTH each, MULTU/DIVU result registers.

## Operation
- Codes: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 MULTU, 12 DIVU. Codes 13–15 complete as single-cycle ops with `alu_out` = 0 and `overflow` = 0.
- Shifts: `busA` shifted by `busB[SHW-1:0]`. SRA replicates `busA[WIDTH-1]`.
- SLT/SLTU: `alu_out` = {WIDTH-1 zeros, lt}.
- ADD/SUB: wrap modulo 2^WIDTH. `overflow` = signed overflow (operand signs equal and result sign differs for ADD; operand signs differ and result sign ≠ `busA` sign for SUB).
- MULTU: shift-add, one bit per cycle, 2·WIDTH product. `{hi,lo}` = product; `alu_out` = lo.
- DIVU: restoring, one bit per cycle. `lo` = quotient, `hi` = remainder, `alu_out` = lo. Divide by zero needs no special case: it yields `lo` = all ones and `hi` = `busA`.
- Single-cycle ops leave `hi`/`lo` unchanged. MULTU/DIVU hold `alu_out`, `zero_flag`, `overflow` (cleared to 0), `hi`, `lo` stable until DONE, then load them together.
- FSM states and transitions:
  - IDLE → DONE on `start` with a single-cycle op.
  - IDLE → RUN on `start` with MULTU/DIVU.
  - RUN → DONE after exactly WIDTH iteration cycles.
  - DONE → IDLE unconditionally.
- `start` is ignored outside IDLE. No queuing.

## Timing
- Reset: state IDLE; `busy` 0, `done` 0, `alu_out` 0, `zero_flag` 1, `overflow` 0, `hi` 0, `lo` 0; iteration counter 0.
- Single-cycle op: `start` at edge N → `done` = 1 and result valid after edge N+1. Peak throughput is one op per 2 cycles.
- MULTU/DIVU: `start` at edge N → `busy` from N+1; `done` and results after edge N+WIDTH+1.
- `done` is high only in DONE, exactly one cycle per accepted op.
- `rst` asserted during RUN or DONE: next edge applies reset values; the partial result is discarded and no `done` is produced.
- `start` and `rst` in the same cycle: reset wins.

## Configuration
- `ALU_DIV_EN` defined: divider datapath built; DIVU behaves as above.
- Not defined: no divider logic. Code 12 is treated as an undefined code (single-cycle, `alu_out` = 0). `hi`/`lo` are unchanged.

## Structure
- `alu_pkg`: opcode localparams (ALU_ADD … ALU_DIVU), FSM state enum (IDLE, RUN, DONE).
- Sub-module `alu_muldiv`: shared WIDTH-cycle shift engine for MULTU/DIVU, with a load/step interface and iteration counter. The top level holds the FSM, single-cycle ops and the result registers.

## Test plan
- Reset then idle → `zero_flag` = 1; `busy`, `done`, `alu_out`, `hi`, `lo` all 0.
- ADD 0x7FFFFFFF + 1 → after 1 cycle `done` = 1, `alu_out` = 0x80000000, `overflow` = 1. Then SUB 5 − 5 → `alu_out` = 0, `zero_flag` = 1, `overflow` = 0.
- SRA 0x80000000 by 4 → 0xF8000000. SLT 0xFFFFFFFF < 1 → 1; SLTU of the same operands → 0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `done` exactly 33 cycles after `start`; `hi` = 0xFFFFFFFE, `lo` = 0x00000001. A `start` pulsed mid-run is ignored.
- DIVU 100 / 7 → `lo` = 14, `hi` = 2. DIVU 9 / 0 → `lo` = 0xFFFFFFFF, `hi` = 9. Without `ALU_DIV_EN`: `alu_out` = 0 after 1 cycle, `hi`/`lo` unchanged.
- `rst` asserted at cycle 10 of a MULTU → no `done`, all outputs at reset values. The next ADD 2 + 3 → 5.
